// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: stores a short program of (A, func) operations entered
// from switches and replays it at a fixed tick rate, pulsing reg_en once per
// issue so the downstream accumulator captures one ALU result per tick.
// Optional build macro LOOP_EN: replay wraps to slot 0 forever instead of
// stopping in DONE after a single pass.
module alu_op_sequencer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         load,
    input  logic [3:0]                   load_a,
    input  logic [2:0]                   load_func,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         clear,
    output logic [3:0]                   op_a,
    output logic [2:0]                   op_func,
    output logic                         reg_en,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TICK_DIV);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic            overflow_q, overflow_d;
    logic            load_prev, start_prev;
    logic            load_edge, start_edge;
    logic            mem_we;
    logic            last_slot;
    logic [6:0]      mem [DEPTH];
    logic [6:0]      slot_op;

    assign load_edge  = load & ~load_prev;
    assign start_edge = start & ~start_prev;
    assign last_slot  = (CW'(rd_ptr_q) == (count_q - CW'(1)));

    // State register, counters, pointers and edge-detect history.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            tick_q     <= '0;
            overflow_q <= 1'b0;
            load_prev  <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            tick_q     <= tick_d;
            overflow_q <= overflow_d;
            load_prev  <= load;
            start_prev <= start;
        end
    end

    // Program storage: one write per accepted load edge at slot count.
    // NOTE: the program memory has no reset; count bounds which slots are
    // valid, so stale contents are never issued and the array maps to RAM.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[count_q[PW-1:0]] <= {load_a, load_func};
        end
    end

    // Next-state and issue logic; abort overrides everything and keeps the program.
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        tick_d     = tick_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        reg_en     = 1'b0;

        if (abort) begin
            state_d  = S_IDLE;
            rd_ptr_d = '0;
            tick_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        count_d    = '0;
                        overflow_d = 1'b0;
                    end else if (start_edge && (count_q != '0)) begin
                        rd_ptr_d = '0;
                        tick_d   = '0;
                        state_d  = S_RUN;
                    end else if (load_edge) begin
                        if (count_q == COUNT_FULL) begin
                            overflow_d = 1'b1;
                        end else begin
                            mem_we  = 1'b1;
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (tick_q == TICK_LAST) begin
                        reg_en = 1'b1;
                        tick_d = '0;
                        if (last_slot) begin
`ifdef LOOP_EN
                            rd_ptr_d = '0;
`else
                            // Keep the pointer on the last slot so DONE holds its op.
                            state_d = S_DONE;
`endif
                        end else begin
                            rd_ptr_d = rd_ptr_q + PW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_DONE: begin
                    if (start_edge) begin
                        rd_ptr_d = '0;
                        tick_d   = '0;
                        state_d  = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Operand outputs: current slot while replaying or finished, zero when idle.
    always_comb begin
        slot_op = mem[rd_ptr_q];
        if (state_q == S_IDLE) begin
            slot_op = '0;
        end
    end

    assign op_a     = slot_op[6:3];
    assign op_func  = slot_op[2:0];
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with DEPTH=4, TICK_DIV=4.
// A program-level model (queue of ops, elapsed cycles since start) predicts
// every output each cycle; directed literal checks pin the model itself.
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;
    localparam int TD    = 4;
`ifdef LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_a = '0;
    logic [2:0] load_func = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] op_a;
    logic [2:0] op_func;
    logic       reg_en;
    logic       busy;
    logic       done;
    logic [2:0] count;
    logic       overflow;

    alu_op_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD)) dut (
        .clock(clock), .reset_n(reset_n), .load(load), .load_a(load_a),
        .load_func(load_func), .start(start), .abort(abort), .clear(clear),
        .op_a(op_a), .op_func(op_func), .reg_en(reg_en), .busy(busy),
        .done(done), .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- program-level model ----------------
    logic [6:0] m_prog[$];
    bit         m_ovf;
    int         m_mode;   // 0 idle, 1 run, 2 done
    int         m_k;      // cycles spent in RUN since the start edge
    bit         m_pl, m_ps;

    always @(posedge clock) begin
        bit le, se;
        int n;
        if (!reset_n) begin
            m_prog.delete();
            m_ovf = 0; m_mode = 0; m_k = 0; m_pl = 0; m_ps = 0;
        end else begin
            le = load && !m_pl;
            se = start && !m_ps;
            n  = m_prog.size();
            if (abort) begin
                m_mode = 0;
            end else begin
                case (m_mode)
                    0: begin
                        if (clear) begin
                            m_prog.delete();
                            m_ovf = 0;
                        end else if (se && n > 0) begin
                            m_mode = 1; m_k = 0;
                        end else if (le) begin
                            if (n == DEPTH) m_ovf = 1;
                            else m_prog.push_back({load_a, load_func});
                        end
                    end
                    1: begin
                        if (((m_k + 1) % TD == 0) && ((m_k / TD) % n == n - 1) && !LOOP)
                            m_mode = 2;
                        else
                            m_k++;
                    end
                    default: begin
                        if (se) begin m_mode = 1; m_k = 0; end
                    end
                endcase
            end
            m_pl = load;
            m_ps = start;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        logic [6:0] e_op;
        int n;
        if (cmp_en) begin
            n = m_prog.size();
            if (m_mode == 0)      e_op = '0;
            else if (m_mode == 1) e_op = m_prog[(m_k / TD) % n];
            else                  e_op = m_prog[n - 1];
            check("op_a", op_a, e_op[6:3]);
            check("op_func", op_func, e_op[2:0]);
            check("reg_en", reg_en, (m_mode == 1) && ((m_k + 1) % TD == 0) && !abort);
            check("busy", busy, m_mode == 1);
            check("done", done, m_mode == 2);
            check("count", count, n);
            check("overflow", overflow, m_ovf);
        end
    end

    // ---------------- issue log for literal checks ----------------
    typedef struct {
        int         c;
        logic [3:0] a;
        logic [2:0] f;
    } issue_t;
    issue_t log_q[$];
    bit     done_seen;
    int     done_cyc;

    always @(negedge clock) begin
        if (cmp_en && reg_en === 1'b1) log_q.push_back('{cyc, op_a, op_func});
        if (cmp_en && done === 1'b1 && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic load_op(input logic [3:0] a, input logic [2:0] f);
        load_a = a; load_func = f; load = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
    endtask

    task automatic pulse_abort();
        abort = 1'b1; step(1); abort = 1'b0; step(1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(1); clear = 1'b0; step(1);
    endtask

    task automatic wait_issues(input int n, input int budget);
        int i = 0;
        while (log_q.size() < n && i < budget) begin
            step(1);
            i++;
        end
        check("wait_issues", log_q.size(), n);
    endtask

    initial begin
        int s;
        bit saw9;

        // Reset
        step(1);
        cmp_en = 1'b1;
        step(1);
        reset_n = 1'b1;
        step(1);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_op_a", op_a, 0);

        // 1: two loads
        load_op(4'd3, 3'b000);
        load_op(4'd5, 3'b001);
        check("t1_count", count, 2);
        check("t1_overflow", overflow, 0);
        check("t1_busy", busy, 0);
        check("t1_op_a", op_a, 0);

        // 3: replay with start held high (no second edge)
        log_q.delete();
        done_seen = 1'b0;
        s = cyc;
        start = 1'b1;
        step(17);
        check("t3_issues", log_q.size(), LOOP ? 4 : 2);
        for (int i = 0; i < log_q.size(); i++) begin
            check("t3_issue_cycle", log_q[i].c - s, 4 * (i + 1));
            check("t3_issue_a", log_q[i].a, (i % 2 == 0) ? 3 : 5);
            check("t3_issue_f", log_q[i].f, (i % 2 == 0) ? 0 : 1);
        end
        if (!LOOP) begin
            check("t3_done_seen", done_seen, 1);
            check("t3_done_cycle", done_cyc - s, 9);
            check("t3_done_op_a", op_a, 5);
        end
        start = 1'b0;
        pulse_abort();
        check("t3_abort_busy", busy, 0);
        check("t3_abort_count", count, 2);

        // 4: start with empty program
        pulse_clear();
        check("t4_clear_count", count, 0);
        log_q.delete();
        start = 1'b1; step(1); start = 1'b0;
        step(6);
        check("t4_busy", busy, 0);
        check("t4_no_issue", log_q.size(), 0);

        // 2: overfill, run, clear
        load_op(4'd1, 3'd1);
        load_op(4'd2, 3'd2);
        load_op(4'd3, 3'd3);
        load_op(4'd4, 3'd4);
        check("t2_ovf_before", overflow, 0);
        load_op(4'd9, 3'd7);
        check("t2_count", count, 4);
        check("t2_overflow", overflow, 1);
        log_q.delete();
        start = 1'b1; step(1); start = 1'b0;
        step(22);
        saw9 = 1'b0;
        foreach (log_q[i]) if (log_q[i].a == 4'd9) saw9 = 1'b1;
        check("t2_fifth_never_issued", saw9, 0);
        check("t2_issues", log_q.size(), LOOP ? 5 : 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            check("t2_issue_a", log_q[i].a, i + 1);
        pulse_abort();
        check("t2_ovf_kept", overflow, 1);
        pulse_clear();
        check("t2_clear_count", count, 0);
        check("t2_clear_ovf", overflow, 0);

        // 5: abort after first issue, then restart from slot 0
        load_op(4'd7, 3'd2);
        load_op(4'd8, 3'd3);
        load_op(4'd9, 3'd4);
        log_q.delete();
        start = 1'b1; step(1); start = 1'b0;
        wait_issues(1, 12);
        abort = 1'b1;
        step(1);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_reg_en", reg_en, 0);
        check("t5_abort_count", count, 3);
        abort = 1'b0;
        step(3);
        check("t5_no_more_issue", log_q.size(), 1);
        log_q.delete();
        s = cyc;
        start = 1'b1; step(1); start = 1'b0;
        step(12);
        check("t5_restart_issues", log_q.size(), 3);
        for (int i = 0; i < 3 && i < log_q.size(); i++) begin
            check("t5_restart_cycle", log_q[i].c - s, 4 * (i + 1));
            check("t5_restart_a", log_q[i].a, 7 + i);
        end
        pulse_abort();

        // 6: reset mid-slot while replaying
        log_q.delete();
        start = 1'b1; step(1); start = 1'b0;
        step(2);
        check("t6_busy_before", busy, 1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check("t6_busy", busy, 0);
        check("t6_reg_en", reg_en, 0);
        check("t6_count", count, 0);
        check("t6_op_a", op_a, 0);
        step(8);
        check("t6_no_issue", log_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
